exe_div_unit: RTL and testbench
===============================

Name: exe_div_unit

Overview:
- Iterative radix-2 restoring divider in the execute stage, directly downstream of the decode/execute pipeline register.
- Consumes the E-stage operands (srcaE, writedataE) and the DIV/DIVU decode.
- Holds the E stage through the hazard unit with a stall request until the quotient (LO) and remainder (HI) are ready for the HI/LO write.
- Divide is cancelled by the exception flush.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  exception flush; cancels any divide in progress
- startE  input  1  DIV/DIVU instruction present in E stage (held high while E stalls)
- signedE  input  1  1=DIV, 0=DIVU
- advanceE  input  1  E stage advances this cycle (no other stall source)
- srcaE  input  WIDTH  dividend (rs)
- srcbE  input  WIDTH  divisor (rt)
- stall_div  output  1  stall request to hazard unit
- div_valid  output  1  result valid; qualifies the HI/LO write
- div_zero  output  1  divisor was zero; valid with div_valid
- hi_out  output  WIDTH  remainder
- lo_out  output  WIDTH  quotient

Behaviour:
- Reset: state IDLE, hi_out=0, lo_out=0, div_valid=0, div_zero=0, iteration count=0. stall_div=0 unless startE=1 in the same cycle.
- States:
  - IDLE: startE=1 and flush=0 → latch |srcaE|, |srcbE| (magnitudes only when signedE=1), quotient sign = sign(a)^sign(b), remainder sign = sign(a), zero flag = (srcbE==0). Go to BUSY with count=0.
  - BUSY: one restoring step per cycle: shift partial remainder left with the next dividend bit, subtract divisor, set quotient bit if no borrow. After step count=WIDTH-1, apply sign fix, register hi_out/lo_out, go to DONE.
  - DONE: div_valid=1. advanceE=1 → IDLE. Otherwise stay in DONE with outputs held. startE is ignored in DONE; it is the same instruction.
- stall_div is combinational: (IDLE & startE) | BUSY, gated by ~flush. DONE never stalls.
- Latency:
  - startE first seen in IDLE at cycle T.
  - stall_div high for cycles T..T+WIDTH (WIDTH+1 cycles).
  - div_valid high from T+WIDTH+1.
- Arithmetic:
  - Signed results: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) → lo=0x80000000, hi=0. No trap.
  - Divisor zero (either signedness) → lo=all ones, hi=srcaE raw value, div_zero=1. The sign fix is bypassed.
- Flush: any state → IDLE next cycle. div_valid=0 next cycle, stall_div=0 in the flush cycle. hi_out/lo_out keep their last values. Flush wins over startE.
- Reset mid-operation: identical to flush, plus hi_out/lo_out cleared.
- hi_out/lo_out change only on the BUSY→DONE transition (or on reset).

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: divisor zero detected in IDLE skips BUSY. Go IDLE→DONE directly with the divide-by-zero results. stall_div high for cycle T only; div_valid at T+1.
- Undefined: divide-by-zero takes the full WIDTH-cycle path and produces the same results at T+WIDTH+1.

Test Plan:
- DIVU 100/7, advanceE=1 at DONE → stall_div high 33 cycles, then div_valid=1, lo=14, hi=2; IDLE the following cycle.
- DIV 0xFFFFFF9C(-100)/7 → lo=0xFFFFFFF2(-14), hi=0xFFFFFFFE(-2); DIV 100/0xFFFFFFF9(-7) → lo=-14, hi=2.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 5/0 → lo=0xFFFFFFFF, hi=5, div_zero=1. With DIV_ZERO_FAST_EN, valid one cycle after start.
- Start divide, assert flush at step 10 → stall_div=0 in the flush cycle, div_valid never rises, state IDLE. A new startE next cycle completes correctly.
- DONE with advanceE=0 for 3 cycles while startE stays high → div_valid held, no restart, hi/lo stable. advanceE=1 → IDLE.
- Back-to-back DIVU (100/7 then 9/3) with startE high in the cycle after DONE → second result lo=3, hi=0, latency again 33 stall cycles.

Source files
------------

// File: rtl/exe_div_unit_if.sv
// exe_div_unit_if
// Purpose: bundles the E-stage divide request, the hazard-unit stall request
//          and the HI/LO result of the execute-stage divider into one port.
// Signals:
//   flush     exception flush, cancels a divide in progress
//   startE    DIV/DIVU present in E (held high while E stalls)
//   signedE   1 = DIV, 0 = DIVU
//   advanceE  E stage advances this cycle
//   srcaE     dividend (rs)
//   srcbE     divisor (rt)
//   stall_div stall request to the hazard unit
//   div_valid result valid, qualifies the HI/LO write
//   div_zero  divisor was zero, valid with div_valid
//   hi_out    remainder
//   lo_out    quotient
// Modports: master = pipeline/E-stage side, slave = divider.
interface exe_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             startE;
    logic             signedE;
    logic             advanceE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             stall_div;
    logic             div_valid;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output flush, startE, signedE, advanceE, srcaE, srcbE,
        input  stall_div, div_valid, div_zero, hi_out, lo_out
    );

    modport slave (
        input  flush, startE, signedE, advanceE, srcaE, srcbE,
        output stall_div, div_valid, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/exe_div_unit.sv
// exe_div_unit
// Purpose: iterative radix-2 restoring divider for the execute stage. Takes
//          the E-stage operands on DIV/DIVU, stalls E through the hazard unit
//          for WIDTH+1 cycles, then presents quotient (LO) and remainder (HI)
//          with div_valid until E advances. Exception flush cancels the divide.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    exe_div_unit_if.slave (request, stall, result signals)
// Parameter WIDTH must match the WIDTH of the connected interface.
// Optional feature: define DIV_ZERO_FAST_EN to finish a divide by zero one
//   cycle after start instead of running the full WIDTH-step loop.
module exe_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    exe_div_unit_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             zero_f;

    // dvd holds the dividend magnitude; its MSB is consumed each step and the
    // new quotient bit enters at the LSB, so after WIDTH steps it is the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] raw_a;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             step;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [WIDTH-1:0] m;
        m = (is_signed && v[WIDTH-1]) ? -v : v;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign accept = (state == IDLE) && bus.startE && !bus.flush;
    assign step   = (state == BUSY) && !bus.flush;

    // One restoring step: the W+1 bit difference goes negative exactly when
    // the shifted remainder is smaller than the divisor.
    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs};
    assign no_borrow = ~diff[WIDTH];
    assign rem_next  = no_borrow ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {dvd[WIDTH-2:0], no_borrow};

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = (bus.srcbE == '0) ? DONE : BUSY;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                if (count == LAST_STEP) state_d = DONE;
            end
            DONE: begin
                // startE is still the same instruction here, so only advanceE matters.
                if (bus.advanceE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            zero_f <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                count  <= '0;
                zero_f <= (bus.srcbE == '0);
`ifdef DIV_ZERO_FAST_EN
                if (bus.srcbE == '0) begin
                    hi_q <= bus.srcaE;
                    lo_q <= '1;
                end
`endif
            end else if (step) begin
                count <= count + CNT_W'(1);
                if (count == LAST_STEP) begin
                    // Divide by zero reports the raw dividend and bypasses the sign fix.
                    if (zero_f) begin
                        hi_q <= raw_a;
                        lo_q <= '1;
                    end else begin
                        hi_q <= apply_sign(rem_next, r_neg);
                        lo_q <= apply_sign(quo_next, q_neg);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dvd   <= magnitude(bus.srcaE, bus.signedE);
            dvs   <= magnitude(bus.srcbE, bus.signedE);
            rem   <= '0;
            raw_a <= bus.srcaE;
            q_neg <= bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
            r_neg <= bus.signedE & bus.srcaE[WIDTH-1];
        end else if (step) begin
            dvd <= quo_next;
            rem <= rem_next;
        end
    end

    assign bus.stall_div = !bus.flush && (((state == IDLE) && bus.startE) || (state == BUSY));
    assign bus.div_valid = (state == DONE);
    assign bus.div_zero  = (state == DONE) && zero_f;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// tb_exe_div_unit
// Purpose: self-checking bench for exe_div_unit. Directed cases plus random
//          DIV/DIVU operands compared against an arithmetic reference model;
//          also checks stall length, result hold in DONE, flush and reset.
// Ports: none (top-level bench). Honours DIV_ZERO_FAST_EN for stall length.
module tb_exe_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_div_unit_if #(.WIDTH(W)) bus ();

    exe_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic z);
        longint sa, sb, q, r;
        if (b == '0) begin
            lo = '1;
            hi = a;
            z  = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[W-1:0];
            hi = r[W-1:0];
            z  = 1'b0;
        end else begin
            lo = a / b;
            hi = a % b;
            z  = 1'b0;
        end
    endtask

    function automatic int exp_stalls(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == '0) ? 1 : W + 1;
`else
        return (b == '0) ? W + 1 : W + 1;
`endif
    endfunction

    // Starts a divide on the next cycle, waits for div_valid, holds DONE for
    // 'hold' cycles with advanceE low, then advances in one further cycle.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input int hold);
        logic [W-1:0] eh, el;
        logic ez;
        int stalls;
        bit got, moved;
        model(a, b, sgn, eh, el, ez);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.startE   = 1'b1;
        bus.signedE  = sgn;
        bus.srcaE    = a;
        bus.srcbE    = b;
        bus.advanceE = 1'b0;
        stalls = 0;
        got    = 1'b0;
        moved  = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (bus.div_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.stall_div) stalls++;
            if (bus.hi_out !== last_hi || bus.lo_out !== last_lo) moved = 1'b1;
            @(negedge clk);
        end
        check("valid_timeout", 64'(got), 64'd1);
        check("stall_cycles", 64'(stalls), 64'(exp_stalls(b)));
        check("hilo_before_done", 64'(moved), 64'd0);
        check("lo", 64'(bus.lo_out), 64'(el));
        check("hi", 64'(bus.hi_out), 64'(eh));
        check("div_zero", 64'(bus.div_zero), 64'(ez));
        check("stall_in_done", 64'(bus.stall_div), 64'd0);
        last_hi = eh;
        last_lo = el;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 64'(bus.div_valid), 64'd1);
            check("hold_stall", 64'(bus.stall_div), 64'd0);
            check("hold_lo", 64'(bus.lo_out), 64'(el));
            check("hold_hi", 64'(bus.hi_out), 64'(eh));
        end
        @(negedge clk);
        bus.advanceE = 1'b1;
        #1;
        check("adv_valid", 64'(bus.div_valid), 64'd1);
    endtask

    task automatic idle_check();
        @(negedge clk);
        bus.startE   = 1'b0;
        bus.advanceE = 1'b0;
        #1;
        check("idle_valid", 64'(bus.div_valid), 64'd0);
        check("idle_stall", 64'(bus.stall_div), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        bit rose;
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.startE   = 1'b0;
        bus.signedE  = 1'b0;
        bus.advanceE = 1'b0;
        bus.srcaE    = '0;
        bus.srcbE    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        check("rst_valid", 64'(bus.div_valid), 64'd0);
        check("rst_zero", 64'(bus.div_zero), 64'd0);
        check("rst_stall", 64'(bus.stall_div), 64'd0);
        bus.startE = 1'b1;
        #1;
        check("rst_stall_start", 64'(bus.stall_div), 64'd1);
        bus.startE = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // directed cases
        do_div(32'd100, 32'd7, 1'b0, 0);
        idle_check();
        do_div(32'hFFFFFF9C, 32'd7, 1'b1, 0);
        idle_check();
        do_div(32'd100, 32'hFFFFFFF9, 1'b1, 0);
        idle_check();
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        idle_check();
        do_div(32'd5, 32'd0, 1'b0, 0);
        idle_check();
        do_div(32'hFFFFFFF7, 32'd0, 1'b1, 0);
        idle_check();
        do_div(32'd1000, 32'd3, 1'b0, 3);
        idle_check();

        // back-to-back: second start in the cycle right after DONE advances
        do_div(32'd100, 32'd7, 1'b0, 0);
        do_div(32'd9, 32'd3, 1'b0, 0);
        idle_check();

        // flush partway through, restart on the following cycle
        @(negedge clk);
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd12345;
        bus.srcbE   = 32'd17;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_stall", 64'(bus.stall_div), 64'd0);
        check("flush_hi", 64'(bus.hi_out), 64'(last_hi));
        check("flush_lo", 64'(bus.lo_out), 64'(last_lo));
        do_div(32'd12345, 32'd17, 1'b0, 0);
        idle_check();

        // flush partway through, then stay idle: valid must never rise
        @(negedge clk);
        bus.startE  = 1'b1;
        bus.signedE = 1'b1;
        bus.srcaE   = 32'hFFFF0000;
        bus.srcbE   = 32'd3;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush  = 1'b0;
        bus.startE = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.div_valid || bus.stall_div) rose = 1'b1;
            @(negedge clk);
        end
        check("flush_no_valid", 64'(rose), 64'd0);
        check("flush_keep_lo", 64'(bus.lo_out), 64'(last_lo));

        // reset in the middle of a divide clears the results
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd77;
        bus.srcbE   = 32'd5;
        repeat (5) @(negedge clk);
        reset      = 1'b1;
        bus.startE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_hi", 64'(bus.hi_out), 64'd0);
        check("mid_rst_lo", 64'(bus.lo_out), 64'd0);
        check("mid_rst_valid", 64'(bus.div_valid), 64'd0);
        check("mid_rst_stall", 64'(bus.stall_div), 64'd0);
        last_hi = '0;
        last_lo = '0;

        // random operands
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = $urandom;
                3:       rb = -W'($urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
